uart_cmd_ctrl: RTL and testbench
================================

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter: CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter: BAUD_RATE, default 9600, serial link rate in baud.
REQ-003 Parameter: TIMEOUT_CLKS, default (CLK_FREQ/BAUD_RATE)*20, inter-byte timeout in clocks.
REQ-004 Port: clk, input, 1, single system clock; all state changes on rising edge.
REQ-005 Port: rst, input, 1, asynchronous active-high reset.
REQ-006 Port: rx_data, input, 8, received byte from the UART receiver, sampled only when rx_valid=1.
REQ-007 Port: rx_valid, input, 1, high for one clock per received byte.
REQ-008 Port: cmd, output, 8, command byte of the last good frame.
REQ-009 Port: payload, output, 32, payload of the last good frame; byte0 in [7:0]; unused bytes zero.
REQ-010 Port: len, output, 3, payload length of the last good frame (0..4).
REQ-011 Port: cmd_valid, output, 1, one-clock pulse per good frame.
REQ-012 Port: err, output, 1, one-clock pulse per aborted frame.
REQ-013 Port: err_code, output, 2, abort reason, held until next err: 1=bad length, 2=checksum, 3=timeout.
REQ-014 Port: busy, output, 1, high whenever state is not IDLE.

Function
REQ-015 Frame format: 0x24 ('$'), CMD, LEN, LEN payload bytes, CSUM; CSUM = XOR of CMD, LEN and all payload bytes.
REQ-016 States: IDLE, CMD, LEN, DATA, CSUM; one byte consumed per rx_valid cycle, back-to-back valids each accepted.
REQ-017 IDLE: rx_valid with 0x24 -> CMD; any other byte ignored, no err.
REQ-018 CMD: rx_valid stores CMD, seeds running XOR with it -> LEN.
REQ-019 LEN: value 0 -> CSUM; 1..4 -> DATA with byte index 0; 5..255 -> err pulse, err_code=1, -> IDLE.
REQ-020 DATA: each byte stored at index position in a staging register, XORed into checksum; after LEN bytes -> CSUM.
REQ-021 0x24 inside CMD/LEN/DATA/CSUM is treated as ordinary data; no resynchronisation.
REQ-022 CSUM: match -> cmd, payload, len updated and cmd_valid pulsed in the clock after the CSUM rx_valid; mismatch -> err pulse, err_code=2; both -> IDLE.
REQ-023 Staging register cleared on entry to CMD so unused payload bytes read zero.
REQ-024 cmd, payload, len change only when cmd_valid pulses; failed frames never alter them.
REQ-025 Timeout counter clears on every rx_valid and on entry to IDLE; counts every clock outside IDLE.
REQ-026 Counter reaching TIMEOUT_CLKS with no rx_valid -> err pulse, err_code=3, -> IDLE.
REQ-027 rx_valid in the same clock as timeout expiry: byte accepted, no timeout.
REQ-028 cmd_valid and err never asserted in the same clock.
REQ-029 Latency: cmd_valid/err one clock after the deciding rx_valid (registered outputs).

Reset
REQ-030 rst asserted: state=IDLE immediately; cmd=0, payload=0, len=0, cmd_valid=0, err=0, err_code=0, busy=0, counter=0.
REQ-031 rst mid-frame discards the partial frame without an err pulse; first byte after release is parsed from IDLE.

Verification
REQ-032 Bytes 24 46 02 50 47 53 -> one cmd_valid; cmd=0x46, len=2, payload=0x00004750; err never high.
REQ-033 Bytes 24 41 00 41 -> cmd_valid; cmd=0x41, len=0, payload=0; then 24 46 01 50 00 -> err, err_code=2, outputs still 0x41/0/0.
REQ-034 Bytes 24 46 05 -> err, err_code=1 one clock after LEN byte; busy low next clock.
REQ-035 Bytes 24 46 02 50 then idle TIMEOUT_CLKS clocks -> err, err_code=3; next frame 24 47 01 41 07 -> cmd_valid, payload=0x00000041.
REQ-036 Noise 46 50 47 41 in IDLE -> busy stays 0, no err or cmd_valid; rst pulse after 24 46 -> busy=0 asynchronously, no err.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_ctrl
// Brief    : Parses '$' CMD LEN PAYLOAD CSUM frames from a UART byte stream.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_ctrl #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD_RATE    = 9600,
    parameter int TIMEOUT_CLKS = (CLK_FREQ / BAUD_RATE) * 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  cmd,
    output logic [31:0] payload,
    output logic [2:0]  len,
    output logic        cmd_valid,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        busy
);

    localparam int                 c_CNT_W    = ($clog2(TIMEOUT_CLKS) > 0) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]         c_SOF      = 8'h24;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4
    } state_t;

    state_t             r_state;
    logic [7:0]         r_cmd_stage;
    logic [2:0]         r_len_stage;
    logic [1:0]         r_idx;
    logic [31:0]        r_stage;
    logic [7:0]         r_xor;
    logic [c_CNT_W-1:0] r_tmo_cnt;
    logic [7:0]         r_cmd;
    logic [31:0]        r_payload;
    logic [2:0]         r_len;
    logic               r_cmd_valid;
    logic               r_err;
    logic [1:0]         r_err_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cmd_stage <= 8'h00;
            r_len_stage <= 3'd0;
            r_idx       <= 2'd0;
            r_stage     <= 32'h0;
            r_xor       <= 8'h00;
            r_tmo_cnt   <= '0;
            r_cmd       <= 8'h00;
            r_payload   <= 32'h0;
            r_len       <= 3'd0;
            r_cmd_valid <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 2'd0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_err       <= 1'b0;
            if (r_state == S_IDLE) begin
                r_tmo_cnt <= '0;
                if (rx_valid && rx_data == c_SOF) begin
                    r_stage <= 32'h0;
                    r_state <= S_CMD;
                end
            end else if (rx_valid) begin
                // A byte arriving on the expiry clock wins over the timeout.
                r_tmo_cnt <= '0;
                case (r_state)
                    S_CMD: begin
                        r_cmd_stage <= rx_data;
                        r_xor       <= rx_data;
                        r_state     <= S_LEN;
                    end
                    S_LEN: begin
                        r_xor <= r_xor ^ rx_data;
                        if (rx_data == 8'd0) begin
                            r_len_stage <= 3'd0;
                            r_state     <= S_CSUM;
                        end else if (rx_data <= 8'd4) begin
                            r_len_stage <= rx_data[2:0];
                            r_idx       <= 2'd0;
                            r_state     <= S_DATA;
                        end else begin
                            r_err      <= 1'b1;
                            r_err_code <= 2'd1;
                            r_state    <= S_IDLE;
                        end
                    end
                    S_DATA: begin
                        r_stage[{r_idx, 3'b000} +: 8] <= rx_data;
                        r_xor                         <= r_xor ^ rx_data;
                        r_idx                         <= r_idx + 2'd1;
                        if ({1'b0, r_idx} == r_len_stage - 3'd1) begin
                            r_state <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        if (rx_data == r_xor) begin
                            r_cmd       <= r_cmd_stage;
                            r_payload   <= r_stage;
                            r_len       <= r_len_stage;
                            r_cmd_valid <= 1'b1;
                        end else begin
                            r_err      <= 1'b1;
                            r_err_code <= 2'd2;
                        end
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (r_tmo_cnt == c_TMO_LAST) begin
                r_err      <= 1'b1;
                r_err_code <= 2'd3;
                r_tmo_cnt  <= '0;
                r_state    <= S_IDLE;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end
    end

    assign cmd       = r_cmd;
    assign payload   = r_payload;
    assign len       = r_len;
    assign cmd_valid = r_cmd_valid;
    assign err       = r_err;
    assign err_code  = r_err_code;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_ctrl
// Brief    : Scoreboard bench for uart_cmd_ctrl frame parsing, errors, timeout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_ctrl;

    localparam int c_TMO = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  cmd;
    logic [31:0] payload;
    logic [2:0]  len;
    logic        cmd_valid;
    logic        err;
    logic [1:0]  err_code;
    logic        busy;

    uart_cmd_ctrl #(
        .CLK_FREQ    (2000),
        .BAUD_RATE   (100),
        .TIMEOUT_CLKS(c_TMO)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .cmd      (cmd),
        .payload  (payload),
        .len      (len),
        .cmd_valid(cmd_valid),
        .err      (err),
        .err_code (err_code),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [7:0]  cmd;
        logic [31:0] payload;
        logic [2:0]  len;
        logic [1:0]  code;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [7:0]  frm[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [7:0]  h_cmd = 8'h00;
    logic [31:0] h_payload = 32'h0;
    logic [2:0]  h_len = 3'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every output event must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && (cmd_valid || err)) begin
            chk("cmd_valid_err_exclusive", {31'b0, cmd_valid && err}, 32'd0);
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_event: cmd_valid=%0b err=%0b err_code=%0d expected none",
                         cmd_valid, err, err_code);
            end else begin
                e = q.pop_front();
                chk("event_kind_err", {31'b0, err}, {31'b0, e.is_err});
                chk("event_cycle", cyc, e.cyc);
                chk("cmd", {24'b0, cmd}, {24'b0, e.cmd});
                chk("payload", payload, e.payload);
                chk("len", {29'b0, len}, {29'b0, e.len});
                if (e.is_err) chk("err_code", {30'b0, err_code}, {30'b0, e.code});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frm();
        foreach (frm[i]) send_byte(frm[i]);
    endtask

    task automatic push_good(input logic [7:0] c, input logic [31:0] p, input logic [2:0] l, input int at);
        exp_t x;
        h_cmd = c; h_payload = p; h_len = l;
        x.is_err = 1'b0; x.cmd = c; x.payload = p; x.len = l; x.code = 2'd0; x.cyc = at;
        q.push_back(x);
    endtask

    task automatic push_err(input logic [1:0] code, input int at);
        exp_t x;
        x.is_err = 1'b1; x.cmd = h_cmd; x.payload = h_payload; x.len = h_len; x.code = code; x.cyc = at;
        q.push_back(x);
    endtask

    // Send all bytes but the last, register the expectation, then the deciding byte.
    task automatic frame_good(input logic [7:0] c, input logic [31:0] p, input logic [2:0] l);
        logic [7:0] last;
        last = frm.pop_back();
        send_frm();
        push_good(c, p, l, cyc + 1);
        send_byte(last);
    endtask

    task automatic frame_err(input logic [1:0] code);
        logic [7:0] last;
        last = frm.pop_back();
        send_frm();
        push_err(code, cyc + 1);
        send_byte(last);
    endtask

    task automatic wait_drain(input string name, input int bound);
        for (int i = 0; i < bound && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk(name, q.size(), 0);
        q.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd", {24'b0, cmd}, 32'h0);
        chk("rst_payload", payload, 32'h0);
        chk("rst_len", {29'b0, len}, 32'h0);
        chk("rst_flags", {28'b0, cmd_valid, err, err_code}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        frm = '{8'h46, 8'h50, 8'h47, 8'h41};
        foreach (frm[i]) begin
            send_byte(frm[i]);
            chk("noise_busy", {31'b0, busy}, 32'h0);
        end
        repeat (3) @(posedge clk);
        #1;

        frm = '{8'h24, 8'h46, 8'h02, 8'h50, 8'h47, 8'h53};
        frame_good(8'h46, 32'h0000_4750, 3'd2);
        wait_drain("drain_two_byte", 5);

        frm = '{8'h24, 8'h41, 8'h00, 8'h41};
        frame_good(8'h41, 32'h0, 3'd0);
        wait_drain("drain_len0", 5);
        frm = '{8'h24, 8'h46, 8'h01, 8'h50, 8'h00};
        frame_err(2'd2);
        wait_drain("drain_bad_csum", 5);

        frm = '{8'h24, 8'h10, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h50};
        frame_good(8'h10, 32'h4433_2211, 3'd4);
        wait_drain("drain_len4", 5);

        frm = '{8'h24, 8'h46, 8'h05};
        frame_err(2'd1);
        chk("busy_after_bad_len", {31'b0, busy}, 32'h0);
        @(posedge clk);
        #1;
        chk("busy_next_clk_bad_len", {31'b0, busy}, 32'h0);
        wait_drain("drain_bad_len", 5);

        frm = '{8'h24, 8'h46, 8'h02, 8'h50};
        send_frm();
        chk("busy_mid_frame", {31'b0, busy}, 32'h1);
        push_err(2'd3, cyc + c_TMO);
        wait_drain("drain_timeout", c_TMO + 10);
        chk("busy_after_timeout", {31'b0, busy}, 32'h0);
        frm = '{8'h24, 8'h47, 8'h01, 8'h41, 8'h07};
        frame_good(8'h47, 32'h0000_0041, 3'd1);
        wait_drain("drain_after_timeout", 5);

        // Bytes landing exactly on the expiry clock must keep the frame alive.
        frm = '{8'h24, 8'h47, 8'h01};
        send_frm();
        repeat (c_TMO - 1) @(posedge clk);
        #1;
        send_byte(8'h41);
        repeat (c_TMO - 1) @(posedge clk);
        #1;
        push_good(8'h47, 32'h0000_0041, 3'd1, cyc + 1);
        send_byte(8'h07);
        wait_drain("drain_expiry_edge", 5);

        frm = '{8'h24, 8'h46};
        send_frm();
        chk("busy_before_rst", {31'b0, busy}, 32'h1);
        rst = 1'b1;
        #1;
        chk("busy_async_rst", {31'b0, busy}, 32'h0);
        chk("outputs_async_rst", {cmd, len, err, err_code, cmd_valid}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        h_cmd = 8'h00; h_payload = 32'h0; h_len = 3'd0;
        frm = '{8'h24, 8'h41, 8'h00, 8'h41};
        frame_good(8'h41, 32'h0, 3'd0);
        wait_drain("drain_after_rst", 5);

        repeat (5) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
